rgbw_fifo_ctrl: RTL

RGBW_FIFO_CTRL -- requirements
Module: rgbw_fifo_ctrl

---
 rtl/rgbw_fifo_ctrl_pkg.sv | 15 +
 rtl/rgbw_gap_timer.sv | 30 +++
 rtl/rgbw_fifo_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rgbw_fifo_ctrl_pkg.sv
// Shared types and default sizing for the RGBW FIFO-to-pixel controller.
// Imported by rgbw_fifo_ctrl and rgbw_gap_timer.
package rgbw_fifo_ctrl_pkg;

    localparam int DEF_DATA_SIZE  = 32;
    localparam int DEF_FRAME_LEN  = 64;
    localparam int DEF_GAP_CYCLES = 4800;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } state_t;

endpackage

// File: rtl/rgbw_gap_timer.sv
// Inter-frame latch timer: load, count down, pulse expire on the last cycle.
// expire is high during the final GAP cycle so the FSM leaves on the next edge.
module rgbw_gap_timer
    import rgbw_fifo_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [GW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= GW'(GAP_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == GW'(1));

endmodule

// File: rtl/rgbw_fifo_ctrl.sv
// Pops frames of FRAME_LEN words from a FIFO into a one-deep pixel register,
// then idles GAP_CYCLES cycles. Optional frame_cnt via RGBW_FIFO_CTRL_FRAME_CNT_EN.
module rgbw_fifo_ctrl
    import rgbw_fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] fifo_r_data,
    input  logic                 fifo_r_empty,
    output logic                 fifo_r_en,
    output logic [DATA_SIZE-1:0] px_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic                 px_last,
    output logic                 frame_done,
    output logic                 underrun,
    input  logic                 underrun_clr
`ifdef RGBW_FIFO_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int PW = $clog2(FRAME_LEN + 1);
    localparam logic [PW-1:0] LEN = PW'(FRAME_LEN);

    state_t        state;
    logic [PW-1:0] pop_cnt;
    logic          in_stream;
    logic          more;
    logic          load;
    logic          hs;
    logic          hs_last;
    logic          starve;
    logic          gap_exp;

    assign in_stream = (state == ST_STREAM);
    assign more      = (pop_cnt < LEN);
    assign hs        = px_valid && px_ready;
    assign hs_last   = in_stream && hs && px_last;

    // Refill the pixel register whenever it is empty or being drained.
    assign load = in_stream && (!px_valid || px_ready)
                  && !fifo_r_empty && more;
    assign starve = in_stream && !px_valid && fifo_r_empty && more;

    assign fifo_r_en = load;

    rgbw_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .load  (hs_last),
        .expire(gap_exp)
    );

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state      <= ST_IDLE;
            pop_cnt    <= '0;
            px_data    <= '0;
            px_valid   <= 1'b0;
            px_last    <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (starve) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (en && !fifo_r_empty) begin
                        state   <= ST_STREAM;
                        pop_cnt <= '0;
                    end
                end
                ST_STREAM: begin
                    if (load) begin
                        px_data  <= fifo_r_data;
                        px_valid <= 1'b1;
                        px_last  <= (pop_cnt == LEN - 1'b1);
                        pop_cnt  <= pop_cnt + 1'b1;
                    end else if (hs) begin
                        px_valid <= 1'b0;
                        px_last  <= 1'b0;
                    end
                    if (hs_last) begin
                        state      <= ST_GAP;
                        frame_done <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_exp) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RGBW_FIFO_CTRL_FRAME_CNT_EN
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
